// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver for two motors: period-synchronous command capture, clamping,
// slew limiting, dead-time on reversal and shoot-through-free registered outputs.
module motor_pwm_driver #(
    parameter int PRESCALE     = 196,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [8:0] duty_cycle1_fwd,
    input  logic signed [8:0] duty_cycle1_back,
    input  logic signed [8:0] duty_cycle2_fwd,
    input  logic signed [8:0] duty_cycle2_back,
    output logic              A1A,
    output logic              A1B,
    output logic              B1A,
    output logic              B1B,
    output logic              period_start,
    output logic [1:0]        m1_state,
    output logic [1:0]        m2_state,
    output logic              conflict
);

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DEAD  = 2'd3
    } mstate_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [PW-1:0] LAST_PRE  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);
    localparam logic [8:0]    STEP9     = (RAMP_STEP > 255) ? 9'd255 : 9'(RAMP_STEP);

    function automatic logic [7:0] clamp_cmd(input logic signed [8:0] v);
        return v[8] ? 8'd0 : v[7:0];
    endfunction

    // Moves cur toward goal by at most STEP9; 9-bit math so neither direction wraps.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] goal);
        logic [8:0] up;
        logic [8:0] gap;
        up  = {1'b0, cur} + STEP9;
        gap = {1'b0, cur} - {1'b0, goal};
        if (goal >= cur)
            return (up >= {1'b0, goal}) ? goal : up[7:0];
        else
            return (gap <= STEP9) ? goal : (cur - STEP9[7:0]);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic          tick;
    logic          boundary;
    logic          period_start_q;
    logic          conflict_q, conflict_d;

    logic signed [8:0] fwd_cmd  [2];
    logic signed [8:0] back_cmd [2];
    logic [7:0]        f_cl     [2];
    logic [7:0]        b_cl     [2];
    logic [7:0]        mag      [2];
    mstate_t           tgt_dir  [2];
    logic [1:0]        conflict_hit;

    mstate_t       state_q [2];
    mstate_t       state_d [2];
    logic [7:0]    eff_q   [2];
    logic [7:0]    eff_d   [2];
    logic [DW-1:0] dead_q  [2];
    logic [DW-1:0] dead_d  [2];
    logic [1:0]    drv_a_q, drv_a_d;
    logic [1:0]    drv_b_q, drv_b_d;

    assign fwd_cmd[0]  = duty_cycle1_fwd;
    assign fwd_cmd[1]  = duty_cycle2_fwd;
    assign back_cmd[0] = duty_cycle1_back;
    assign back_cmd[1] = duty_cycle2_back;

    always_comb begin
        tick      = (presc_q == LAST_PRE);
        boundary  = tick && (pwm_cnt_q == 8'd254);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (tick)
            pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
    end

    always_comb begin
        conflict_hit = '0;
        for (int m = 0; m < 2; m++) begin
            state_d[m] = state_q[m];
            eff_d[m]   = eff_q[m];
            dead_d[m]  = dead_q[m];
            f_cl[m]    = clamp_cmd(fwd_cmd[m]);
            b_cl[m]    = clamp_cmd(back_cmd[m]);
            tgt_dir[m] = ST_COAST;
            mag[m]     = 8'd0;
            if (f_cl[m] != 8'd0 && b_cl[m] == 8'd0) begin
                tgt_dir[m] = ST_FWD;
                mag[m]     = f_cl[m];
            end else if (b_cl[m] != 8'd0 && f_cl[m] == 8'd0) begin
                tgt_dir[m] = ST_REV;
                mag[m]     = b_cl[m];
            end
            conflict_hit[m] = (f_cl[m] != 8'd0) && (b_cl[m] != 8'd0);

            if (!enable) begin
                state_d[m] = ST_COAST;
                eff_d[m]   = 8'd0;
                dead_d[m]  = '0;
            end else if (boundary) begin
                case (state_q[m])
                    ST_COAST: begin
                        if (tgt_dir[m] != ST_COAST) begin
                            state_d[m] = tgt_dir[m];
                            eff_d[m]   = ramp_toward(8'd0, mag[m]);
                        end
                    end
                    ST_FWD, ST_REV: begin
                        if (tgt_dir[m] == ST_COAST) begin
                            state_d[m] = ST_COAST;
                            eff_d[m]   = 8'd0;
                        end else if (tgt_dir[m] == state_q[m]) begin
                            eff_d[m] = ramp_toward(eff_q[m], mag[m]);
                        end else begin
                            state_d[m] = ST_DEAD;
                            eff_d[m]   = 8'd0;
                            dead_d[m]  = DEAD_INIT;
                        end
                    end
                    default: begin
                        // Dead time always ends in COAST; the new direction starts a period later.
                        if (dead_q[m] > DW'(1)) begin
                            dead_d[m] = dead_q[m] - DW'(1);
                        end else begin
                            dead_d[m]  = '0;
                            state_d[m] = ST_COAST;
                        end
                    end
                endcase
            end

            drv_a_d[m] = enable && (state_q[m] == ST_FWD) && (pwm_cnt_q < eff_q[m]);
            drv_b_d[m] = enable && (state_q[m] == ST_REV) && (pwm_cnt_q < eff_q[m]);
        end
        conflict_d = conflict_q | (boundary & (|conflict_hit));
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            pwm_cnt_q      <= 8'd0;
            period_start_q <= 1'b0;
            conflict_q     <= 1'b0;
            drv_a_q        <= '0;
            drv_b_q        <= '0;
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= ST_COAST;
                eff_q[m]   <= 8'd0;
                dead_q[m]  <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= boundary;
            conflict_q     <= conflict_d;
            drv_a_q        <= drv_a_d;
            drv_b_q        <= drv_b_d;
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= state_d[m];
                eff_q[m]   <= eff_d[m];
                dead_q[m]  <= dead_d[m];
            end
        end
    end

    assign A1A          = drv_a_q[0];
    assign A1B          = drv_b_q[0];
    assign B1A          = drv_a_q[1];
    assign B1B          = drv_b_q[1];
    assign period_start = period_start_q;
    assign m1_state     = state_q[0];
    assign m2_state     = state_q[1];
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: arithmetic reference model checked every cycle, plus
// per-period duty counts and event checks with hand-computed values.
module tb_motor_pwm_driver;

    localparam int P   = 2;
    localparam int PER = 255 * P;

    logic              clk_50 = 1'b0;
    logic              reset;
    logic              enable;
    logic signed [8:0] d1f, d1b, d2f, d2b;
    logic              A1A, A1B, B1A, B1B, period_start, conflict;
    logic [1:0]        m1_state, m2_state;

    motor_pwm_driver #(.PRESCALE(P), .RAMP_STEP(16), .DEAD_PERIODS(2)) dut (
        .clk_50(clk_50), .reset(reset), .enable(enable),
        .duty_cycle1_fwd(d1f), .duty_cycle1_back(d1b),
        .duty_cycle2_fwd(d2f), .duty_cycle2_back(d2b),
        .A1A(A1A), .A1B(A1B), .B1A(B1A), .B1B(B1B),
        .period_start(period_start), .m1_state(m1_state), .m2_state(m2_state),
        .conflict(conflict)
    );

    always #5 clk_50 = ~clk_50;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int clampi(input logic signed [8:0] v);
        if (v < 0) return 0;
        return int'(v);
    endfunction

    // Reference model: time position derived from edges since reset, states as plain ints
    // (0 coast, 1 fwd, 2 rev, 3 dead).
    int mk = 0;
    int ms[2], me[2], md[2], mf[2], mb[2], mt[2], mmag[2];
    int m_cnt;
    bit m_bnd, mc, eps;
    bit eA[2], eB[2];

    initial forever begin
        @(posedge clk_50 or posedge reset);
        if (reset) begin
            mk = 0; mc = 0; eps = 0;
            for (int m = 0; m < 2; m++) begin
                ms[m] = 0; me[m] = 0; md[m] = 0; eA[m] = 0; eB[m] = 0;
            end
        end else begin
            m_cnt = (mk / P) % 255;
            m_bnd = (mk % PER) == PER - 1;
            eps   = m_bnd;
            mf[0] = clampi(d1f); mb[0] = clampi(d1b);
            mf[1] = clampi(d2f); mb[1] = clampi(d2b);
            for (int m = 0; m < 2; m++) begin
                eA[m] = enable && ms[m] == 1 && m_cnt < me[m];
                eB[m] = enable && ms[m] == 2 && m_cnt < me[m];
                mt[m] = (mf[m] > 0 && mb[m] == 0) ? 1 : (mb[m] > 0 && mf[m] == 0) ? 2 : 0;
                mmag[m] = (mt[m] == 1) ? mf[m] : mb[m];
                if (m_bnd && mf[m] > 0 && mb[m] > 0) mc = 1;
                if (!enable) begin
                    ms[m] = 0; me[m] = 0; md[m] = 0;
                end else if (m_bnd) begin
                    if (ms[m] == 3) begin
                        md[m] = md[m] - 1;
                        if (md[m] == 0) ms[m] = 0;
                    end else if (mt[m] == 0) begin
                        ms[m] = 0; me[m] = 0;
                    end else if (ms[m] == 0) begin
                        ms[m] = mt[m];
                        me[m] = (mmag[m] < 16) ? mmag[m] : 16;
                    end else if (ms[m] == mt[m]) begin
                        if (mmag[m] > me[m]) me[m] = (me[m] + 16 < mmag[m]) ? me[m] + 16 : mmag[m];
                        else                 me[m] = (me[m] - 16 > mmag[m]) ? me[m] - 16 : mmag[m];
                    end else begin
                        ms[m] = 3; me[m] = 0; md[m] = 2;
                    end
                end
            end
            mk++;
        end
    end

    initial forever begin
        @(negedge clk_50);
        if (reset)
            chk("cycle_reset", int'({A1A, A1B, B1A, B1B, period_start, m1_state, m2_state, conflict}), 0);
        else
            chk("cycle", int'({A1A, A1B, B1A, B1B, period_start, m1_state, m2_state, conflict}),
                int'({eA[0], eB[0], eA[1], eB[1], eps, 2'(ms[0]), 2'(ms[1]), mc}));
        chk("shoot_through", int'(A1A & A1B) + int'(B1A & B1B), 0);
    end

    // Waits for period_start, then counts each drive output over the following period.
    task automatic measure(output int ca, output int cb, output int c2, output int st1, output int st2);
        int guard = 0;
        while (period_start !== 1'b1 && guard < 2 * PER) begin
            @(negedge clk_50);
            guard++;
        end
        chk("period_wait", int'(period_start === 1'b1), 1);
        st1 = int'(m1_state);
        st2 = int'(m2_state);
        ca = 0; cb = 0; c2 = 0;
        repeat (PER) begin
            @(negedge clk_50);
            ca += int'(A1A);
            cb += int'(A1B);
            c2 += int'(B1A) + int'(B1B);
        end
    endtask

    task automatic period_chk(input string name, input int exp_a, input int exp_b, input int exp_st);
        int ca, cb, c2, st1, st2;
        measure(ca, cb, c2, st1, st2);
        chk($sformatf("%s_A1A", name), ca, exp_a);
        chk($sformatf("%s_A1B", name), cb, exp_b);
        chk($sformatf("%s_m1state", name), st1, exp_st);
        chk($sformatf("%s_motor2", name), c2 + st2, 0);
    endtask

    initial begin
        int ca, cb, c2, st1, st2, guard;
        reset = 1'b0; enable = 1'b1;
        d1f = 9'sd0; d1b = 9'sd0; d2f = -9'sd40; d2b = 9'sd0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("reset_outputs", int'({A1A, A1B, B1A, B1B, period_start, m1_state, m2_state, conflict}), 0);
        reset = 1'b0;
        d1f = 9'sd60;

        period_chk("ramp16", 32, 0, 1);
        period_chk("ramp32", 64, 0, 1);
        period_chk("ramp48", 96, 0, 1);
        period_chk("ramp60", 120, 0, 1);
        period_chk("steady60", 120, 0, 1);

        d1f = 9'sd0; d1b = 9'sd50;
        period_chk("pre_rev", 120, 0, 1);
        period_chk("dead1", 0, 0, 3);
        period_chk("dead2", 0, 0, 3);
        period_chk("coast_gap", 0, 0, 0);
        period_chk("rev16", 0, 32, 2);
        period_chk("rev32", 0, 64, 2);

        d1f = 9'sd100; d1b = 9'sd30;
        period_chk("rev48", 0, 96, 2);
        period_chk("conflict_coast", 0, 0, 0);
        chk("conflict_set", int'(conflict), 1);
        d1f = 9'sd0; d1b = 9'sd0;
        period_chk("legal_a", 0, 0, 0);
        period_chk("legal_b", 0, 0, 0);
        chk("conflict_sticky", int'(conflict), 1);

        d1f = 9'sd60;
        period_chk("idle", 0, 0, 0);
        period_chk("r16", 32, 0, 1);
        period_chk("r32", 64, 0, 1);
        period_chk("r48", 96, 0, 1);
        period_chk("r60", 120, 0, 1);

        guard = 0;
        while (period_start !== 1'b1 && guard < 2 * PER) begin
            @(negedge clk_50);
            guard++;
        end
        chk("mid_wait", int'(period_start === 1'b1), 1);
        ca = 0;
        repeat (200) begin @(negedge clk_50); ca += int'(A1A); end
        d1f = 9'sd200;
        repeat (PER - 200) begin @(negedge clk_50); ca += int'(A1A); end
        chk("mid_change_hold", ca, 120);
        period_chk("after_mid", 152, 0, 1);

        d1f = 9'sd255;
        for (int i = 0; i < 11; i++) measure(ca, cb, c2, st1, st2);
        period_chk("full255", 510, 0, 1);

        @(negedge clk_50);
        #2 reset = 1'b1;
        @(negedge clk_50);
        chk("reset2_outputs", int'({A1A, A1B, B1A, B1B, period_start, m1_state, m2_state, conflict}), 0);
        reset = 1'b0;
        d1f = 9'sd60;
        period_chk("e16", 32, 0, 1);
        period_chk("e32", 64, 0, 1);
        period_chk("e48", 96, 0, 1);
        period_chk("e60", 120, 0, 1);

        repeat (20) @(negedge clk_50);
        chk("pre_drop_A1A", int'(A1A), 1);
        enable = 1'b0;
        @(negedge clk_50);
        chk("drop_A1A", int'(A1A), 0);
        chk("drop_state", int'(m1_state), 0);
        repeat (30) @(negedge clk_50);
        enable = 1'b1;
        period_chk("en_resume", 32, 0, 1);

        d1f = 9'sd0; d1b = 9'sd50;
        period_chk("pre_rev2", 64, 0, 1);
        period_chk("dead_r", 0, 0, 3);
        chk("dead_r2_state", int'(m1_state), 3);
        repeat (7) @(negedge clk_50);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", int'({A1A, A1B, B1A, B1B, period_start, m1_state, m2_state, conflict}), 0);
        @(negedge clk_50);
        reset = 1'b0;
        repeat (4) @(negedge clk_50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream stage of the line follower. Consumes the four signed duty-cycle commands (motor 1 and motor 2, forward and back) and drives the H-bridge inputs A1A/A1B/B1A/B1B.
- Adds period-synchronous duty update, clamping, slew-rate limiting, dead-time on direction reversal, and shoot-through protection, so PID glitches never reach the bridge.

Parameters:
- PRESCALE, 196: clk_50 cycles per PWM tick (≈1 kHz PWM at 255 ticks/period).
- RAMP_STEP, 16: max change of effective duty per PWM period.
- DEAD_PERIODS, 2: full PWM periods with both bridge inputs low on direction reversal.

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- enable  in  1  synchronous; low forces coast
- duty_cycle1_fwd  in  9  signed, motor 1 forward command
- duty_cycle1_back  in  9  signed, motor 1 reverse command
- duty_cycle2_fwd  in  9  signed, motor 2 forward command
- duty_cycle2_back  in  9  signed, motor 2 reverse command
- A1A  out  1  motor 1 forward drive
- A1B  out  1  motor 1 reverse drive
- B1A  out  1  motor 2 forward drive
- B1B  out  1  motor 2 reverse drive
- period_start  out  1  one-cycle pulse at each PWM period start
- m1_state  out  2  motor 1 state: 0 COAST, 1 FWD, 2 REV, 3 DEAD
- m2_state  out  2  motor 2 state, same encoding
- conflict  out  1  sticky; set when fwd>0 and back>0 on the same motor at a boundary

Behaviour:
- Reset (async, active-high):
  - Prescaler = 0, pwm_cnt = 0.
  - Both motors COAST, effective duty eff = 0, dead counters = 0.
  - All outputs 0, including conflict.
- Timebase:
  - tick asserts when prescaler == PRESCALE-1; prescaler then wraps to 0.
  - pwm_cnt (8 bit) advances on tick over 0..254 and wraps to 0.
  - Boundary = tick while pwm_cnt == 254.
  - period_start is registered: high for exactly the one cycle after a boundary.
- Input clamp, per command: value < 0 → 0; otherwise the low 8 bits (0..255). Commands are sampled only at a boundary. Changes between boundaries have no effect.
- Target per motor, from clamped fwd f and back b:
  - f > 0, b = 0 → FWD with magnitude f.
  - b > 0, f = 0 → REV with magnitude b.
  - f = b = 0 → COAST.
  - f > 0 and b > 0 → COAST, and conflict is set (cleared only by reset).
- State machine per motor; transitions happen only at a boundary:
  - COAST → FWD or REV: eff = min(mag, RAMP_STEP).
  - FWD/REV, same-direction target: eff moves toward mag by at most RAMP_STEP. No overshoot; the arithmetic is 9-bit internally with no wrap.
  - FWD/REV, COAST target: go to COAST, eff = 0.
  - FWD ↔ REV target: go to DEAD, eff = 0, dead counter = DEAD_PERIODS.
  - DEAD: counter decrements each boundary. When it reaches 0, go to COAST regardless of target. The next boundary then enters the target direction (ramping from 0). Target changes during DEAD do not shorten the dead time.
- Outputs, registered, one cycle after pwm_cnt changes:
  - xA = (state == FWD) && (pwm_cnt < eff).
  - xB = (state == REV) && (pwm_cnt < eff).
  - eff = 255 gives 100 % on; eff = 0 gives 0 %.
  - xA and xB are never both high.
- enable low:
  - On the next clock: all bridge outputs 0, both motors COAST, eff = 0, dead counters cleared.
  - Timebase and period_start keep running.
  - After enable rises, commands are next acted on at the following boundary.
- Reset mid-operation: outputs drop to 0 asynchronously, with no dead-time obligation.

Test Plan (sim uses PRESCALE=2, RAMP_STEP=16, DEAD_PERIODS=2):
- Reset, then duty_cycle1_fwd = 60, others 0 → motor 1 eff follows 16, 32, 48, 60 over successive periods. A1A high for pwm_cnt < eff each period; A1B, B1A, B1B stay 0.
- Steady motor 1 FWD 60, then switch to duty_cycle1_back = 50, fwd = 0 → sequence DEAD for 2 periods, then COAST for 1 period, then REV with eff 16. A1A = A1B = 0 throughout DEAD and COAST. Never both high.
- duty_cycle2_fwd = -40, duty_cycle2_back = 0 → clamps to 0. Motor 2 stays COAST, B1A = B1B = 0.
- duty_cycle1_fwd = 100 and duty_cycle1_back = 30 → COAST, conflict latches 1 and stays 1 after inputs return to legal values; only reset clears it.
- Command change mid-period (fwd 60 → 200 at pwm_cnt = 100) → duty unchanged until the next period_start, then ramps by 16. With fwd = 255 reached, A1A high for the entire period.
- Drop enable at pwm_cnt = 10 while FWD 60 → A1A = 0 on the next clock, m1_state = 0. Assert reset mid-DEAD → all outputs 0 immediately and states 0.
